// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state type and sizing constants for the fetch sequencer.
package fetch_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int BUF_DEPTH = 2;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;
endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: 2-entry synchronous FIFO with push/pop/flush and occupancy count.
module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_q [BUF_DEPTH];
  logic         rd_q, wr_q;
  logic [1:0]   cnt_q;
  logic         do_push, do_pop;
  assign do_pop  = pop_i && cnt_q != 2'd0;
  assign do_push = push_i && (cnt_q != 2'(BUF_DEPTH) || do_pop);
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= !wr_q;
      end
      if (do_pop) rd_q <= !rd_q;
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner issuing instruction-memory reads with a 2-entry skid buffer to decode.
// Optional FETCH_PERF_EN adds saturating fetch/stall performance counters.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = 5,
  parameter int START_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_instruction,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              busy,
  output logic              done,
  output logic              addr_err
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_fetched,
  output logic [15:0]       perf_stall
`endif
);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PC0   = ADDR_W'(START_PC);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);
  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          pc_q, pc_d, ipc_q, ipc_d;
  logic                       infl_q, infl_d, kill_q, kill_d, err_q, err_d;
  logic [1:0]                 cnt;
  logic [ADDR_W+DATA_W-1:0]   head;
  logic                       active, redir, redir_ok, pop, push, issue, launch;
  assign active   = state_q == FETCH || state_q == DRAIN;
  assign redir    = active && redirect_valid;
  assign redir_ok = redir && redirect_addr < LIMIT;
  assign pop      = inst_valid && inst_ready;
  assign launch   = (state_q == IDLE || state_q == DONE) && start;
  // Entries being popped this cycle free their slot, which sustains one word per cycle.
  assign issue    = state_q == FETCH && !(halt && !redir_ok) && (cnt - 2'(pop) + 2'(infl_q)) < 2'(BUF_DEPTH);
  assign push     = infl_q && !kill_q && !redir_ok;
  assign err_d    = redir && !redir_ok;
  always_comb begin
    state_d = state_q;
    pc_d    = issue ? pc_q + 1'b1 : pc_q;
    ipc_d   = issue ? pc_q : ipc_q;
    infl_d  = issue;
    kill_d  = issue && redir_ok;
    if (redir_ok) begin
      state_d = FETCH;
      pc_d    = redirect_addr;
    end else if (state_q == FETCH && halt) begin
      state_d = DRAIN;
    end else if (issue && pc_q == LAST) begin
      state_d = DRAIN;
    end else if (state_q == DRAIN && !infl_q && cnt == 2'd0) begin
      state_d = DONE;
    end else if (launch) begin
      state_d = FETCH;
      pc_d    = PC0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= PC0;
      ipc_q   <= '0;
      infl_q  <= 1'b0;
      kill_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      infl_q  <= infl_d;
      kill_q  <= kill_d;
      err_q   <= err_d;
    end
  end
  fetch_skid_fifo #(.W(ADDR_W + DATA_W)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redir_ok),
    .din_i   ({ipc_q, mem_instruction}),
    .dout_o  (head),
    .count_o (cnt)
  );
  assign mem_addr   = pc_q;
  assign inst_valid = cnt != 2'd0;
  assign inst_data  = inst_valid ? head[DATA_W-1:0] : '0;
  assign inst_pc    = inst_valid ? head[ADDR_W+DATA_W-1:DATA_W] : '0;
  assign busy       = active;
  assign done       = state_q == DONE;
  assign addr_err   = err_q;
`ifdef FETCH_PERF_EN
  logic [15:0] fetched_q, stall_q;
  always_ff @(posedge clk) begin
    if (reset || launch) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      if (push && fetched_q != 16'hFFFF) fetched_q <= fetched_q + 16'd1;
      if (inst_valid && !inst_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end
  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed + randomized bench with a next-expected-PC stream scoreboard.
module tb_fetch_sequencer;
  localparam int AW = 8, DW = 32, DEPTH = 5;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, halt = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b0;
  logic [AW-1:0] redirect_addr = '0, mem_addr, inst_pc;
  logic [DW-1:0] mem_instruction, inst_data;
  logic inst_valid, busy, done, addr_err;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched, perf_stall;
`endif
  logic [DW-1:0] mem [256];
  int n_chk = 0, n_fail = 0;
  int exp_pc = 0, since = -1;
  bit halted = 0, err_exp = 0;
  int got[$];

  fetch_sequencer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .START_PC(0)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .mem_addr(mem_addr), .mem_instruction(mem_instruction),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .busy(busy), .done(done), .addr_err(addr_err)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_instruction <= mem[mem_addr];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Stream model: every accepted word must be the next sequential PC since the last start/redirect.
  always @(negedge clk) begin
    if (since >= 0) begin
      since++;
      if (since == 1) check("done_early", done, 0);
      else begin
        check("done_rise", done, 1);
        check("busy_end", busy, 0);
        since = -1;
      end
    end
    check("addr_err", addr_err, err_exp);
    err_exp = !reset && busy && redirect_valid && redirect_addr >= DEPTH;
    if (reset) begin
      exp_pc = 0;
      halted = 0;
      since = -1;
    end else begin
      if (inst_valid && inst_ready) begin
        check("inst_pc", inst_pc, exp_pc);
        check("inst_data", inst_data, mem[exp_pc]);
        got.push_back(int'(inst_pc));
        exp_pc++;
        if (exp_pc == DEPTH && !halted) since = 0;
      end
      if (busy && redirect_valid && redirect_addr < DEPTH) begin
        exp_pc = int'(redirect_addr);
        halted = 0;
        since = -1;
      end else if (busy && halt) halted = 1;
      else if (!busy && start) begin
        exp_pc = 0;
        halted = 0;
        since = -1;
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic kick();
    got.delete();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 80) begin
      cyc();
      k++;
    end
    check(tag, done, 1);
  endtask

  task automatic check_seq(input string tag, input int n);
    check({tag, "_len"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) check(tag, got[i], i);
  endtask

  initial begin
    int e3[6] = '{0, 1, 1, 2, 3, 4};
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    cyc(2);
    reset = 1'b0;
    @(negedge clk);
    check("rst_addr", mem_addr, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_data", inst_data, 0);
    check("rst_pc", inst_pc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    // Full-rate run: valid from cycle 3, one word per cycle, done two cycles after the last.
    inst_ready = 1'b1;
    kick();
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("t1_valid", inst_valid, c >= 3 && c <= 7);
      if (c >= 3 && c <= 7) check("t1_pc", inst_pc, c - 3);
      check("t1_done", done, c == 9);
    end
    check_seq("t1_seq", 5);
    // Back-pressure: buffer fills, address holds at 2, order preserved.
    inst_ready = 1'b0;
    kick();
    cyc(5);
    @(negedge clk);
    check("t2_addr", mem_addr, 2);
    check("t2_head", inst_pc, 0);
    cyc(3);
    check("t2_addr_hold", mem_addr, 2);
    inst_ready = 1'b1;
    wait_done("t2_done");
    check_seq("t2_seq", 5);
    // Redirect to 1 while pc 2 is in flight.
    kick();
    cyc(3);
    redirect_valid = 1'b1;
    redirect_addr = 8'd1;
    cyc();
    redirect_valid = 1'b0;
    wait_done("t3_done");
    check("t3_len", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) check("t3_seq", got[i], e3[i]);
    // Out-of-range redirect: one-cycle error pulse, stream untouched.
    kick();
    cyc(3);
    redirect_valid = 1'b1;
    redirect_addr = 8'd7;
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t4_err_hi", addr_err, 1);
    @(negedge clk);
    check("t4_err_lo", addr_err, 0);
    wait_done("t4_done");
    check_seq("t4_seq", 5);
    // Halt after two issues, then restart.
    kick();
    cyc(2);
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    wait_done("t5_done");
    check_seq("t5_seq", 2);
    kick();
    wait_done("t5_rerun");
    check_seq("t5_reseq", 5);
    // Reset with a full buffer.
    inst_ready = 1'b0;
    kick();
    cyc(6);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("t6_valid", inst_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_addr", mem_addr, 0);
    // Randomized runs against the stream model.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 8; i++) mem[i] = $urandom;
      inst_ready = 1'b1;
      kick();
      for (int k = 0; k < 40; k++) begin
        inst_ready = $urandom_range(3) != 0;
        redirect_valid = $urandom_range(15) == 0;
        redirect_addr = 8'($urandom_range(7));
        halt = $urandom_range(31) == 0;
        start = $urandom_range(15) == 0;
        cyc();
      end
      redirect_valid = 1'b0;
      halt = 1'b0;
      start = 1'b0;
      inst_ready = 1'b1;
      wait_done("rnd_done");
    end
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Sequences reads of the instruction memory for the single-cycle datapath. The block owns the program counter and drives the memory address. It tracks the memory's 1-cycle registered read latency and hands instructions to decode over a valid/ready handshake. A 2-entry output buffer absorbs decode back-pressure, because an issued read cannot be cancelled in the memory.

Parameters:
ADDR_W, 8, address/PC width
DATA_W, 32, instruction width
DEPTH, 5, number of valid instruction words; valid addresses are 0..DEPTH-1
START_PC, 0, PC loaded when a run starts

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
start  in  1  pulse; begins a run from START_PC when in IDLE or DONE
halt  in  1  pulse; stop issuing new reads and finish in-flight/buffered ones
redirect_valid  in  1  branch/jump request
redirect_addr  in  ADDR_W  new PC
mem_addr  out  ADDR_W  address to instruction memory, sampled by memory at rising edge
mem_instruction  in  DATA_W  memory data, valid the cycle after its address was sampled
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts
inst_data  out  DATA_W  instruction word
inst_pc  out  ADDR_W  address inst_data was fetched from
busy  out  1  state is FETCH or DRAIN
done  out  1  level, state is DONE
addr_err  out  1  1-cycle pulse on an out-of-range redirect

Behaviour:
- Reset (synchronous, active-high, clk): state=IDLE, pc=START_PC, inflight=0, buffer empty. Outputs: mem_addr=START_PC, inst_valid=0, inst_data=0, inst_pc=0, busy=0, done=0, addr_err=0. Reset mid-run discards in-flight and buffered data.
- mem_addr is always the registered pc, so the address is stable for the whole cycle.
- Issue condition: state==FETCH and (buffer occupancy + inflight) < 2. On issue: inflight<=1, inflight_pc<=pc, pc<=pc+1.
- Capture: if inflight and not killed, mem_instruction/inflight_pc are pushed into the buffer the cycle after issue.
- Total latency: start to first inst_valid is 3 cycles (load pc, issue, capture).
- Buffer: 2-entry FIFO. Head drives inst_data/inst_pc; inst_valid=!empty. Pop on inst_valid&&inst_ready. Push and pop in the same cycle when full are legal. The credit rule guarantees no overflow.
- Sustained throughput: 1 instruction/cycle with inst_ready held high.
- FSM states and transitions:
  - IDLE: start -> FETCH, pc<=START_PC.
  - FETCH: on issuing address DEPTH-1 -> DRAIN. On halt -> DRAIN, issuing nothing further.
  - DRAIN: once inflight==0 and buffer empty -> DONE.
  - DONE: done=1. start -> FETCH, pc<=START_PC.
- Redirect, accepted in FETCH or DRAIN:
  - Flush the buffer and set the kill flag on any in-flight read so it is not captured.
  - pc<=redirect_addr and state<=FETCH.
  - redirect_addr >= DEPTH: ignored entirely, addr_err pulses.
- Simultaneous events, priority reset > redirect > halt > start. A redirect together with a pop: the flush wins and the popped entry counts as consumed.
- PC arithmetic is ADDR_W bits and never wraps, because issue stops at DEPTH-1.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_fetched [15:0], counting buffer pushes, and perf_stall [15:0], counting cycles with inst_valid && !inst_ready. Both saturate at 0xFFFF, clear on reset, and clear on start from IDLE/DONE.
- Undefined: the ports and counters do not exist.

Decomposition:
- Package fetch_pkg: FSM state typedef (IDLE, FETCH, DRAIN, DONE), default ADDR_W/DATA_W constants, buffer depth constant 2.
- One sub-module, fetch_skid_fifo: 2-entry synchronous FIFO carrying {pc, instruction}, with push/pop/flush/count.

Test Plan:
- Reset, start, inst_ready=1, memory words 0..4 = A..E -> inst_valid from cycle 3, A..E with inst_pc 0..4 on consecutive cycles, then done=1.
- inst_ready=0 after start -> at most 2 instructions buffered, mem_addr holds 2, no loss. Release -> order A,B,C,D,E preserved.
- Redirect to 1 while C is in flight -> C never appears; next outputs are B(pc1), C(pc2), ...
- Redirect to 7 with DEPTH=5 -> addr_err 1-cycle pulse, stream unchanged.
- Halt after 2 issues -> only A,B delivered, DRAIN then DONE. Start again -> A..E.
- Reset asserted mid-run with a full buffer -> next cycle inst_valid=0, busy=0, state IDLE.
